// File: rtl/adder_seq_pkg.sv
// Shared types, widths and configuration checks for the adder operand sequencer.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int PAIR_W     = 2 * DEF_DATA_W;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit pkg_fits(input int num, input int data_w, input int pkg_w);
        return (num * 2 * data_w) <= pkg_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock result FIFO; push and pop may coincide at any fill level.
module sync_fifo
    import adder_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;
    logic              empty_s;
    logic              full_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction

    // Handshake qualification: empty pops are dropped, a full push needs a same-cycle pop.
    always_comb begin
        empty_s   = (count_r == '0);
        full_s    = (count_r == CNT_W'(DEPTH));
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Unpacks a wide package into operand pairs for the external adder and streams
// the sums out through a credit-protected result FIFO; also owns the adder reset.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int PACKAGE_WIDTH = 1600,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int NUM           = 100,
    parameter int ADD_LAT       = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int RST_CYCLES    = 10
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     pkt_valid_i,
    output logic                     pkt_ready_o,
    input  logic [PACKAGE_WIDTH-1:0] pkt_data_i,
    output logic [DATA_W-1:0]        op_a_o,
    output logic [DATA_W-1:0]        op_b_o,
    output logic                     op_valid_o,
    output logic                     dp_reset_o,
    input  logic [DATA_W-1:0]        res_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [DATA_W-1:0]        res_data_o,
    output logic                     pkt_done_o,
    output logic                     busy_o
);

    localparam int PW      = 2 * DATA_W;
    localparam int SHIFT_W = NUM * PW;
    localparam int CNT_W   = cnt_width(NUM);
    localparam int RST_W   = cnt_width(RST_CYCLES);
    localparam int FCNT_W  = cnt_width(FIFO_DEPTH);
    localparam int OCC_W   = cnt_width(FIFO_DEPTH + ADD_LAT + 2);

    localparam logic [1:0] S_INIT  = INIT;
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_DRAIN = DRAIN;

    if (!pkg_fits(NUM, DATA_W, PACKAGE_WIDTH) || ADD_LAT < 1 || FIFO_DEPTH < ADD_LAT + 1 || RST_CYCLES < 1) begin : g_bad_cfg
        $error("adder_seq_ctrl: illegal parameter combination");
    end

    logic [1:0]         state_r;
    logic [RST_W-1:0]   rst_cnt_r;
    logic [SHIFT_W-1:0] shift_r;
    logic [CNT_W-1:0]   pair_cnt_r;
    logic [DATA_W-1:0]  op_a_r;
    logic [DATA_W-1:0]  op_b_r;
    logic               op_valid_r;
    logic               op_last_r;
    logic [ADD_LAT-1:0] track_r;
    logic [ADD_LAT-1:0] last_track_r;
    logic               dp_reset_r;
    logic               pkt_ready_r;
    logic               pkt_done_r;
    logic               busy_r;

    logic [FCNT_W-1:0]  fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic [OCC_W-1:0]   inflight_s;
    logic [OCC_W-1:0]   occ_s;
    logic [OCC_W-1:0]   limit_s;
    logic               credit_ok_s;
    logic               accept_s;
    logic               issue_s;
    logic               last_pair_s;
    logic               last_push_s;

    // In-flight pairs: the one on the adder inputs now plus those still inside the adder.
    always_comb begin
        inflight_s = OCC_W'(op_valid_r);
        for (int i = 0; i < ADD_LAT; i++) begin
            inflight_s = inflight_s + OCC_W'(track_r[i]);
        end
    end

    // Handshakes and the issue credit check (a same-cycle pop frees a slot).
    always_comb begin
        pop_s       = res_ready_i && !fifo_empty_s;
        push_s      = track_r[ADD_LAT-1];
        last_push_s = push_s && last_track_r[ADD_LAT-1];
        occ_s       = OCC_W'(fifo_count_s) + inflight_s;
        limit_s     = OCC_W'(FIFO_DEPTH) + OCC_W'(pop_s);
        credit_ok_s = (occ_s < limit_s) && !(fifo_full_s && !pop_s);
        accept_s    = (state_r == S_IDLE) && pkt_ready_r && pkt_valid_i;
        issue_s     = (state_r == S_ISSUE) && credit_ok_s;
        last_pair_s = (pair_cnt_r == CNT_W'(NUM - 1));
    end

    // Control FSM: datapath reset timing, package accept, pair counting, drain.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= S_INIT;
            rst_cnt_r   <= '0;
            dp_reset_r  <= 1'b1;
            pkt_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            shift_r     <= '0;
            pair_cnt_r  <= '0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (rst_cnt_r == RST_W'(RST_CYCLES - 1)) begin
                        dp_reset_r  <= 1'b0;
                        pkt_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept_s) begin
                        shift_r     <= pkt_data_i[SHIFT_W-1:0];
                        pair_cnt_r  <= '0;
                        pkt_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_s) begin
                        shift_r    <= shift_r >> PW;
                        pair_cnt_r <= pair_cnt_r + 1'b1;
                        if (last_pair_s) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_push_s) begin
                        pkt_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_INIT;
                    rst_cnt_r   <= '0;
                    dp_reset_r  <= 1'b1;
                    pkt_ready_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    // Operand registers and the adder-latency tracker; last-pair marks travel alongside.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            op_a_r       <= '0;
            op_b_r       <= '0;
            op_valid_r   <= 1'b0;
            op_last_r    <= 1'b0;
            track_r      <= '0;
            last_track_r <= '0;
            pkt_done_r   <= 1'b0;
        end else begin
            op_valid_r <= issue_s;
            op_last_r  <= issue_s && last_pair_s;
            if (issue_s) begin
                op_a_r <= shift_r[DATA_W-1:0];
                op_b_r <= shift_r[PW-1:DATA_W];
            end
            track_r      <= (track_r << 1'b1) | ADD_LAT'(op_valid_r);
            last_track_r <= (last_track_r << 1'b1) | ADD_LAT'(op_last_r);
            pkt_done_r   <= last_push_s;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (reset_ni),
        .push      (push_s),
        .push_data (res_i),
        .pop       (pop_s),
        .head      (res_data_o),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign op_a_o      = op_a_r;
    assign op_b_o      = op_b_r;
    assign op_valid_o  = op_valid_r;
    assign dp_reset_o  = dp_reset_r;
    assign pkt_ready_o = pkt_ready_r;
    assign pkt_done_o  = pkt_done_r;
    assign busy_o      = busy_r;
    assign res_valid_o = !fifo_empty_s;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed vector table, multi-cycle corner sequences and
// random packages checked against an arithmetic model of the operand sums.
module tb_adder_seq_ctrl;

    localparam int PW  = 64;
    localparam int DW  = 8;
    localparam int NUM = 4;
    localparam int AL  = 1;
    localparam int FD  = 4;
    localparam int RC  = 10;
    localparam int LAT = NUM + AL + 2;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          pkt_valid_i;
    logic          pkt_ready_o;
    logic [PW-1:0] pkt_data_i;
    logic [DW-1:0] op_a_o;
    logic [DW-1:0] op_b_o;
    logic          op_valid_o;
    logic          dp_reset_o;
    logic [DW-1:0] res_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_data_o;
    logic          pkt_done_o;
    logic          busy_o;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .PACKAGE_WIDTH (PW),
        .DATA_W        (DW),
        .NUM           (NUM),
        .ADD_LAT       (AL),
        .FIFO_DEPTH    (FD),
        .RST_CYCLES    (RC)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .pkt_valid_i (pkt_valid_i),
        .pkt_ready_o (pkt_ready_o),
        .pkt_data_i  (pkt_data_i),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .op_valid_o  (op_valid_o),
        .dp_reset_o  (dp_reset_o),
        .res_i       (res_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .pkt_done_o  (pkt_done_o),
        .busy_o      (busy_o)
    );

    // Behavioural adder with a registered sum (one cycle of latency).
    logic [DW-1:0] sum_r;
    always_ff @(posedge clk) begin
        if (dp_reset_o) sum_r <= '0;
        else            sum_r <= op_a_o + op_b_o;
    end
    assign res_i = sum_r;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_sum(input logic [PW-1:0] p, input int i);
        logic [PW-1:0] t;
        t = p >> (2 * DW * i);
        return DW'((int'(t[DW-1:0]) + int'(t[2*DW-1:DW])) % 256);
    endfunction

    function automatic logic [2*DW-1:0] model_pair(input logic [PW-1:0] p, input int i);
        logic [PW-1:0] t;
        t = p >> (2 * DW * i);
        return {t[DW-1:0], t[2*DW-1:DW]};
    endfunction

    // Monitor: records handshakes, operand pairs and popped results on the falling edge.
    int              cyc = 0;
    logic [DW-1:0]   got_q[$];
    logic [DW-1:0]   exp_q[$];
    logic [2*DW-1:0] op_q[$];
    int              op_cyc_q[$];
    int              acc_hist[$];
    int              done_cnt = 0;
    int              done_cyc = 0;
    int              acc_cnt  = 0;
    int              acc_cyc  = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset_ni) begin
            if (pkt_valid_i && pkt_ready_o) begin
                acc_cnt++;
                acc_cyc = cyc;
                acc_hist.push_back(cyc);
                for (int i = 0; i < NUM; i++) exp_q.push_back(model_sum(pkt_data_i, i));
            end
            if (res_valid_o && res_ready_i) got_q.push_back(res_data_o);
            if (op_valid_o) begin
                op_q.push_back({op_a_o, op_b_o});
                op_cyc_q.push_back(cyc);
            end
            if (pkt_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Consumer ready: 0 = stalled, 1 = always ready, otherwise random.
    int ready_mode = 1;
    initial begin
        res_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       res_ready_i = 1'b0;
                1:       res_ready_i = 1'b1;
                default: res_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        op_q.delete();
        op_cyc_q.delete();
        acc_hist.delete();
    endtask

    task automatic send_pkt(input logic [PW-1:0] p);
        int n;
        n = acc_cnt;
        pkt_valid_i = 1'b1;
        pkt_data_i  = p;
        for (int k = 0; k < 300 && acc_cnt == n; k++) idle(1);
        pkt_valid_i = 1'b0;
        chk("accept_wait", 64'(acc_cnt - n), 64'd1);
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int k = 0; k < bound && done_cnt < target; k++) idle(1);
        chk("done_wait", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic release_reset();
        int   edges;
        logic rdy_early;
        edges     = 0;
        rdy_early = 1'b0;
        reset_ni  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (!dp_reset_o) break;
            rdy_early = rdy_early | pkt_ready_o;
        end
        chk("rst_edges", 64'(edges), 64'(RC));
        chk("ready_rise", 64'(pkt_ready_o), 64'd1);
        chk("ready_early", 64'(rdy_early), 64'd0);
        chk("busy_idle", 64'(busy_o), 64'd0);
        #1;
    endtask

    typedef struct packed {
        logic [63:0] pkt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int base;
        int n;

        vecs[0] = '{pkt: 64'h0807_0605_0403_0201, exp: 32'h0F0B_0703};
        vecs[1] = '{pkt: 64'h0000_FFFF_8080_01FF, exp: 32'h00FE_0000};
        vecs[2] = '{pkt: 64'h1122_3344_5566_7788, exp: 32'h3377_BBFF};

        reset_ni    = 1'b0;
        pkt_valid_i = 1'b0;
        pkt_data_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_a", 64'(op_a_o), 64'd0);
        chk("rst_op_b", 64'(op_b_o), 64'd0);
        chk("rst_op_valid", 64'(op_valid_o), 64'd0);
        chk("rst_pkt_ready", 64'(pkt_ready_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done_o), 64'd0);
        chk("rst_dp_reset", 64'(dp_reset_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd1);
        @(posedge clk);
        #2;
        release_reset();

        // Directed vectors with the consumer always ready.
        for (int v = 0; v < 3; v++) begin
            ready_mode = 1;
            clear_q();
            base = done_cnt;
            send_pkt(vecs[v].pkt);
            wait_done(base + 1, 50);
            idle(3);
            chk("vec_res_count", 64'(got_q.size()), 64'(NUM));
            for (int i = 0; i < NUM; i++) begin
                chk("vec_result", 64'((i < got_q.size()) ? got_q[i] : 8'hxx), 64'(vecs[v].exp[8*i +: 8]));
                chk("vec_op_pair", 64'((i < op_q.size()) ? op_q[i] : 16'hxxxx), 64'(model_pair(vecs[v].pkt, i)));
            end
            chk("vec_latency", 64'(done_cyc - acc_cyc), 64'(LAT));
            chk("vec_done_pulses", 64'(done_cnt - base), 64'd1);
            chk("vec_op_start", 64'((op_cyc_q.size() == NUM) ? op_cyc_q[0] - acc_cyc : -1), 64'd2);
            chk("vec_op_span", 64'((op_cyc_q.size() == NUM) ? op_cyc_q[NUM-1] - op_cyc_q[0] : -1), 64'(NUM - 1));
        end

        // Backpressure: consumer stalled for the whole package, then released.
        ready_mode = 0;
        idle(2);
        clear_q();
        base = done_cnt;
        send_pkt(64'h4030_2010_0A09_0605);
        idle(12);
        chk("bp_op_valid", 64'(op_valid_o), 64'd0);
        chk("bp_op_a_held", 64'(op_a_o), 64'h30);
        chk("bp_op_b_held", 64'(op_b_o), 64'h40);
        chk("bp_res_valid", 64'(res_valid_o), 64'd1);
        chk("bp_no_pops", 64'(got_q.size()), 64'd0);
        chk("bp_done", 64'(done_cnt - base), 64'd1);
        chk("bp_idle_ready", 64'(pkt_ready_o), 64'd1);
        ready_mode = 1;
        idle(8);
        chk("bp_res_count", 64'(got_q.size()), 64'd4);
        chk("bp_res0", 64'((got_q.size() > 0) ? got_q[0] : 8'hxx), 64'h0B);
        chk("bp_res1", 64'((got_q.size() > 1) ? got_q[1] : 8'hxx), 64'h13);
        chk("bp_res2", 64'((got_q.size() > 2) ? got_q[2] : 8'hxx), 64'h30);
        chk("bp_res3", 64'((got_q.size() > 3) ? got_q[3] : 8'hxx), 64'h70);
        chk("bp_empty", 64'(res_valid_o), 64'd0);

        // Back-to-back packages with pkt_valid_i held high.
        clear_q();
        base = done_cnt;
        n = acc_cnt;
        pkt_valid_i = 1'b1;
        pkt_data_i  = vecs[0].pkt;
        for (int k = 0; k < 50 && acc_cnt == n; k++) idle(1);
        pkt_data_i = vecs[1].pkt;
        for (int k = 0; k < 50 && acc_cnt == n + 1; k++) idle(1);
        pkt_valid_i = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt - n), 64'd2);
        wait_done(base + 2, 50);
        idle(3);
        chk("b2b_done_pulses", 64'(done_cnt - base), 64'd2);
        chk("b2b_gap", 64'((acc_hist.size() == 2) ? acc_hist[1] - acc_hist[0] : -1), 64'(LAT));
        chk("b2b_res_count", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 2 * NUM; i++) begin
            chk("b2b_result", 64'((i < got_q.size()) ? got_q[i] : 8'hxx), 64'(vecs[i / NUM].exp[8*(i % NUM) +: 8]));
        end

        // Asynchronous reset after two pairs have been issued.
        clear_q();
        base = done_cnt;
        pkt_valid_i = 1'b1;
        pkt_data_i  = vecs[2].pkt;
        for (int k = 0; k < 50 && op_q.size() < 2; k++) idle(1);
        pkt_valid_i = 1'b0;
        chk("mid_two_ops", 64'(op_q.size()), 64'd2);
        #1;
        reset_ni = 1'b0;
        #1;
        chk("mid_op_a", 64'(op_a_o), 64'd0);
        chk("mid_op_b", 64'(op_b_o), 64'd0);
        chk("mid_op_valid", 64'(op_valid_o), 64'd0);
        chk("mid_pkt_ready", 64'(pkt_ready_o), 64'd0);
        chk("mid_res_valid", 64'(res_valid_o), 64'd0);
        chk("mid_dp_reset", 64'(dp_reset_o), 64'd1);
        chk("mid_busy", 64'(busy_o), 64'd1);
        clear_q();
        @(posedge clk);
        #2;
        idle(2);
        release_reset();
        chk("mid_fifo_empty", 64'(res_valid_o), 64'd0);
        idle(10);
        chk("mid_no_stale", 64'(got_q.size()), 64'd0);
        chk("mid_no_done", 64'(done_cnt - base), 64'd0);

        // Random packages with a randomly stalling consumer.
        ready_mode = 2;
        clear_q();
        base = done_cnt;
        for (int p = 0; p < 20; p++) begin
            send_pkt({$urandom(), $urandom()});
            idle($urandom_range(0, 2));
        end
        wait_done(base + 20, 400);
        ready_mode = 1;
        idle(10);
        chk("rnd_done_pulses", 64'(done_cnt - base), 64'd20);
        chk("rnd_res_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("rnd_result", 64'((i < got_q.size()) ? got_q[i] : 8'hxx), 64'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Operand sequencer for the MyTopLevel adder datapath. It accepts one wide package per handshake and unpacks it into NUM (A,B) operand pairs. It issues the pairs to the adder and streams the adder results out through a small result FIFO. It also owns the adder's synchronous reset, and it throttles issue so that a stalled consumer can never lose a result.

Parameters:
PACKAGE_WIDTH, 1600, width of the input package in bits
DATA_W, 8, operand and result width
NUM, 100, operand pairs per package; NUM*2*DATA_W <= PACKAGE_WIDTH is required (elaboration error otherwise)
ADD_LAT, 1, cycles from operands present on op_a_o/op_b_o to the result being valid on res_i
FIFO_DEPTH, 4, result FIFO entries; must be >= ADD_LAT+1
RST_CYCLES, 10, cycles dp_reset_o is held high after reset_ni releases

Ports:
clk_i  in  1  single clock, all logic on its rising edge
reset_ni  in  1  asynchronous, active-low reset
pkt_valid_i  in  1  package valid
pkt_ready_o  out  1  package accepted when valid&&ready
pkt_data_i  in  PACKAGE_WIDTH  package; pair i is A=[2iW+W-1:2iW], B=[2iW+2W-1:2iW+W], W=DATA_W
op_a_o  out  DATA_W  adder io_A
op_b_o  out  DATA_W  adder io_B
op_valid_o  out  1  op_a_o/op_b_o carry a new pair this cycle
dp_reset_o  out  1  active-high synchronous reset to the adder
res_i  in  DATA_W  adder io_X
res_valid_o  out  1  result FIFO non-empty
res_ready_i  in  1  consumer pops the head when valid&&ready
res_data_o  out  DATA_W  FIFO head
pkt_done_o  out  1  one-cycle pulse when the last result of a package has entered the FIFO
busy_o  out  1  state != IDLE

Behaviour:
- Reset (reset_ni=0, async) clears everything:
  - Outputs: op_a_o=op_b_o=0, op_valid_o=0, pkt_ready_o=0, res_valid_o=0, pkt_done_o=0, dp_reset_o=1, busy_o=1.
  - Internal: FIFO and in-flight tracker emptied; state = INIT.
- FSM states: INIT, IDLE, ISSUE, DRAIN.
- INIT:
  - Counts RST_CYCLES rising edges after reset_ni rises.
  - On the edge reaching RST_CYCLES: dp_reset_o<=0 and state -> IDLE.
- IDLE:
  - pkt_ready_o=1 (registered, high exactly while in IDLE).
  - On accept: latch pkt_data_i into a shift register, pair counter = 0, state -> ISSUE (pkt_ready_o low the next cycle).
- ISSUE, credit rule: a pair may issue only when fifo_count + inflight < FIFO_DEPTH, with the pop of the current cycle counted as freeing a slot.
- ISSUE, when a pair issues:
  - op_a_o/op_b_o <= low 2*DATA_W bits of the shift register; op_valid_o<=1.
  - Shift register >> 2*DATA_W; counter increments.
- ISSUE, when stalled: op_valid_o<=0 and op_a_o/op_b_o hold their last value.
- ISSUE exit: after pair NUM-1 has issued, state -> DRAIN.
- In-flight tracker:
  - ADD_LAT-deep valid shift register fed by op_valid_o.
  - At its tap, res_i is pushed into the FIFO. A pair presented in cycle c is pushed at the end of cycle c+ADD_LAT, so res_valid_o is visible in cycle c+ADD_LAT+1 when the FIFO was empty.
  - inflight = popcount of the tracker.
- DRAIN:
  - When the last pair is pushed into the FIFO, pkt_done_o pulses for 1 cycle and state -> IDLE.
  - Results already in the FIFO remain poppable in IDLE.
- FIFO behaviour:
  - Simultaneous push and pop is legal at any fill level, including full and empty.
  - The credit rule guarantees a push never meets a full FIFO.
  - A pop when empty is ignored.
- Width rules:
  - Results are passed through unmodified; the controller does no arithmetic on them.
  - The pair counter is $clog2(NUM+1) bits.
  - Unused high package bits are ignored.
- Reset mid-operation: the package in progress, in-flight results and FIFO contents are discarded; the INIT sequence reruns.
- Throughput: with res_ready_i held high, 1 pair per cycle, so a package takes NUM + ADD_LAT + 2 cycles from accept to pkt_done_o.

Decomposition:
- Package adder_seq_pkg holds:
  - state enum (INIT, IDLE, ISSUE, DRAIN)
  - default DATA_W
  - PAIR_W = 2*DATA_W
  - function computing the counter widths
  - the elaboration check on NUM against PACKAGE_WIDTH
- Sub-module sync_fifo (parameters DATA_W, DEPTH): push, pop, count, full, empty.
- The controller instantiates sync_fifo; the adder itself stays outside the block.

Test Plan:
Bench parameters: PACKAGE_WIDTH=64, NUM=4, ADD_LAT=1, FIFO_DEPTH=4, RST_CYCLES=10; behavioural adder with a registered sum.
- Reset sequence: release reset_ni -> dp_reset_o high for exactly 10 edges, then low; pkt_ready_o rises in the same cycle dp_reset_o falls.
- Single package pkt_data_i=64'h0807_0605_0403_0201, res_ready_i=1 -> op pairs (01,02),(03,04),(05,06),(07,08) on 4 consecutive cycles; results 03,07,0B,0F in order; one pkt_done_o pulse.
- Wrap-around pairs (FF,01),(80,80),(FF,FF),(00,00) -> results 00,00,FE,00, passed through unmodified.
- Backpressure: res_ready_i=0 throughout -> issue stops with fifo_count+inflight=4, op_valid_o=0, operands held. Then raise res_ready_i -> remaining pairs issue; all 4 results are delivered in order with none lost or duplicated.
- Back-to-back packages with pkt_valid_i held high -> second accepted the cycle after returning to IDLE; 8 results in order; 2 pkt_done_o pulses.
- Assert reset_ni low after 2 pairs issued -> all outputs at reset values immediately (async). After release: INIT reruns, the FIFO is empty, and no stale results appear.
